// File: rtl/sram_test_sequencer_if.sv
// Bus bundle between the SRAM test sequencer and the SRAM comparator/host side.
interface sram_test_sequencer_if #(
  parameter int unsigned DW = 32
);
  logic          start;
  logic          r_i;
  logic [DW-1:0] d_o;
  logic          we_o;
  logic          rd_o;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_cnt;

  modport master (
    input  start, r_i,
    output d_o, we_o, rd_o, busy, done, pass, err_cnt
  );

  modport slave (
    output start, r_i,
    input  d_o, we_o, rd_o, busy, done, pass, err_cnt
  );
endinterface

// File: rtl/sram_test_sequencer.sv
// SRAM test sequencer: writes an incrementing pattern of DEPTH words, idles
// GAP cycles, reads DEPTH words back, and counts comparator mismatches that
// arrive RD_LAT cycles after each read strobe.
module sram_test_sequencer #(
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned GAP    = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_test_sequencer_if.master bus
);

  localparam int unsigned MAX_DG = (DEPTH > GAP) ? DEPTH : GAP;
  localparam int unsigned MAXC   = (MAX_DG > RD_LAT) ? MAX_DG : RD_LAT;
  localparam int unsigned CW     = $clog2(MAXC);

  localparam logic [CW-1:0] LAST_WORD  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_GAP   = (GAP == 0) ? '0 : CW'(GAP - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT:0]   vld_shift;
  logic          sample;
  logic          accept;
  logic [15:0]   err_nxt;
  logic [DW-1:0] d_nxt;
  logic          we_nxt, rd_nxt, busy_nxt, done_nxt;

  // Next state, phase counter and the next value of every registered output.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_WRITE;
          cnt_nxt   = '0;
        end
      end
      S_WRITE: begin
        if (cnt == LAST_WORD) begin
          state_nxt = (GAP == 0) ? S_READ : S_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == LAST_GAP) begin
          state_nxt = S_READ;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_READ: begin
        if (cnt == LAST_WORD) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered copies of the values the next state will present.
    we_nxt   = (state_nxt == S_WRITE);
    rd_nxt   = (state_nxt == S_READ);
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
    d_nxt    = (state_nxt == S_WRITE) ? DW'(cnt_nxt) : '0;
  end

  // Read-valid pipeline and the saturating mismatch count it qualifies.
  always_comb begin
    vld_shift = {vld, bus.rd_o};
    sample    = vld[RD_LAT-1];
    err_nxt   = bus.err_cnt;
    if (sample && !bus.r_i && (bus.err_cnt != '1)) begin
      err_nxt = bus.err_cnt + 16'd1;
    end
  end

  // State, counter, valid pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      vld         <= '0;
      bus.d_o     <= '0;
      bus.we_o    <= 1'b0;
      bus.rd_o    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vld      <= vld_shift[RD_LAT-1:0];
      bus.d_o  <= d_nxt;
      bus.we_o <= we_nxt;
      bus.rd_o <= rd_nxt;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
      if (accept) begin
        bus.err_cnt <= '0;
        bus.pass    <= 1'b0;
      end else begin
        bus.err_cnt <= err_nxt;
        // err_nxt folds in a mismatch sampled in the final drain cycle.
        if (state_nxt == S_DONE) begin
          bus.pass <= (err_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Scoreboard bench for sram_test_sequencer: stimulus queues expected run
// summaries, per-DUT monitors measure each run and compare at the done pulse.
module tb_sram_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sram_test_sequencer_if #(.DW(32)) bus_a ();
  sram_test_sequencer_if #(.DW(32)) bus_b ();

  sram_test_sequencer #(.DW(32), .DEPTH(256), .GAP(10), .RD_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  sram_test_sequencer #(.DW(32), .DEPTH(4), .GAP(0), .RD_LAT(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  typedef struct {
    int wr;
    int gap;
    int rd;
    int drain;
    int len;
    int idle;
    int err;
    bit pass;
    bit dbad;
  } res_t;

  typedef struct {
    res_t cur;
    bit   prev_busy;
    int   since_done;
    bit   fire;
  } mon_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q_a[$];
  res_t q_b[$];
  mon_t m_a = '{cur: '{default: 0}, prev_busy: 1'b0, since_done: 100000, fire: 1'b0};
  mon_t m_b = '{cur: '{default: 0}, prev_busy: 1'b0, since_done: 100000, fire: 1'b0};

  function automatic void chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic void check_run(input string tag, input res_t g, input res_t e);
    chk({tag, ".write_cycles"}, g.wr, e.wr);
    chk({tag, ".gap_cycles"}, g.gap, e.gap);
    chk({tag, ".read_cycles"}, g.rd, e.rd);
    chk({tag, ".drain_cycles"}, g.drain, e.drain);
    chk({tag, ".run_length"}, g.len, e.len);
    chk({tag, ".err_cnt"}, g.err, e.err);
    chk({tag, ".pass"}, int'(g.pass), int'(e.pass));
    chk({tag, ".d_o_pattern_bad"}, int'(g.dbad), int'(e.dbad));
    if (e.idle >= 0) chk({tag, ".idle_before_write"}, g.idle, e.idle);
  endfunction

  function automatic mon_t mon_step(input mon_t m_in, input logic busy, input logic we,
                                    input logic rd, input logic done, input logic pass,
                                    input logic [15:0] err, input logic [31:0] d);
    mon_t m = m_in;
    m.fire = 1'b0;
    if (busy && !m.prev_busy) begin
      m.cur      = '{default: 0};
      m.cur.idle = m.since_done;
    end
    if (busy) m.cur.len++;
    if (we) begin
      if (d != 32'(m.cur.wr)) m.cur.dbad = 1'b1;
      m.cur.wr++;
    end else begin
      if (d != '0) m.cur.dbad = 1'b1;
      if (rd) m.cur.rd++;
      else if (busy && !done) begin
        if (m.cur.rd == 0) m.cur.gap++;
        else m.cur.drain++;
      end
    end
    if (done) begin
      m.cur.err    = int'(err);
      m.cur.pass   = pass;
      m.fire       = 1'b1;
      m.since_done = 0;
    end else if (!busy) begin
      m.since_done++;
    end
    m.prev_busy = busy;
    return m;
  endfunction

  // Monitor for the default-parameter DUT: measure runs, compare at done.
  always @(negedge clk) begin
    m_a = mon_step(m_a, bus_a.busy, bus_a.we_o, bus_a.rd_o, bus_a.done, bus_a.pass,
                   bus_a.err_cnt, bus_a.d_o);
    if (m_a.fire) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a.unexpected_done: got done pulse, expected none");
      end else begin
        check_run("a", m_a.cur, q_a.pop_front());
      end
    end
  end

  // Monitor for the small-parameter DUT.
  always @(negedge clk) begin
    m_b = mon_step(m_b, bus_b.busy, bus_b.we_o, bus_b.rd_o, bus_b.done, bus_b.pass,
                   bus_b.err_cnt, bus_b.d_o);
    if (m_b.fire) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b.unexpected_done: got done pulse, expected none");
      end else begin
        check_run("b", m_b.cur, q_b.pop_front());
      end
    end
  end

  function automatic res_t exp_def(input int idle, input int err, input bit pass);
    res_t e;
    e.wr    = 256;
    e.gap   = 10;
    e.rd    = 256;
    e.drain = 1;
    e.len   = 524;
    e.idle  = idle;
    e.err   = err;
    e.pass  = pass;
    e.dbad  = 1'b0;
    return e;
  endfunction

  // r_i for cycle n after the accept edge; read word k is compared in cycle 268+k.
  function automatic logic r_val(input int mode, input int n);
    case (mode)
      1:       return !(n == 268 || n == 368 || n == 523);
      2:       return !(n <= 266 || n >= 524);
      3:       return !(n == 523);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void chk_zero(input string name);
    int va, vb;
    va = int'((bus_a.d_o != '0) | bus_a.we_o | bus_a.rd_o | bus_a.busy | bus_a.done |
              bus_a.pass | (bus_a.err_cnt != '0));
    vb = int'((bus_b.d_o != '0) | bus_b.we_o | bus_b.rd_o | bus_b.busy | bus_b.done |
              bus_b.pass | (bus_b.err_cnt != '0));
    chk({name, ".a_outputs_nonzero"}, va, 0);
    chk({name, ".b_outputs_nonzero"}, vb, 0);
  endfunction

  task automatic run_a(input int mode, input int ncyc);
    bus_a.r_i = r_val(mode, 0);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      bus_a.r_i   = r_val(mode, n);
    end
    @(negedge clk);
    bus_a.r_i = 1'b1;
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_a.r_i   = 1'b1;
    bus_b.start = 1'b0;
    bus_b.r_i   = 1'b1;
    rst         = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // Clean default run.
    q_a.push_back(exp_def(-1, 0, 1'b1));
    run_a(0, 530);

    // Mismatches on read words 0, 100 and 255.
    q_a.push_back(exp_def(-1, 3, 1'b0));
    run_a(1, 530);

    // Mismatch only on the last read word, sampled in the final drain cycle.
    q_a.push_back(exp_def(-1, 1, 1'b0));
    run_a(3, 530);

    // r_i low only outside the sample slots.
    q_a.push_back(exp_def(-1, 0, 1'b1));
    run_a(2, 530);

    // Reset at read word 50 (cycle 317), with start held during reset.
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 317; n++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      if (n == 317) begin
        rst         = 1'b0;
        bus_a.start = 1'b1;
      end
    end
    @(negedge clk);
    chk_zero("mid_read_reset");
    @(negedge clk);
    chk_zero("start_during_reset");
    rst         = 1'b1;
    bus_a.start = 1'b0;
    q_a.push_back(exp_def(-1, 0, 1'b1));
    run_a(0, 530);

    // start held high: two back-to-back runs with one idle cycle between.
    q_a.push_back(exp_def(-1, 0, 1'b1));
    q_a.push_back(exp_def(1, 0, 1'b1));
    @(negedge clk);
    bus_a.start = 1'b1;
    repeat (540) @(negedge clk);
    bus_a.start = 1'b0;
    repeat (520) @(negedge clk);

    // Small configuration: DEPTH=4, GAP=0, RD_LAT=2.
    begin
      res_t e;
      e.wr    = 4;
      e.gap   = 0;
      e.rd    = 4;
      e.drain = 2;
      e.len   = 11;
      e.idle  = -1;
      e.err   = 0;
      e.pass  = 1'b1;
      e.dbad  = 1'b0;
      q_b.push_back(e);
    end
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0;
    repeat (20) @(negedge clk);

    chk("a.runs_without_done", q_a.size(), 0);
    chk("b.runs_without_done", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_test_sequencer.md
SRAM_TEST_SEQUENCER -- requirements
Module: sram_test_sequencer

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the data bus width.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of words written and then read back (>=2).
REQ-003 The block SHALL have parameter GAP, default 10, meaning the number of idle cycles between the write and read phases (>=0).
REQ-004 The block SHALL have parameter RD_LAT, default 1, meaning the cycles from rd_o high to the corresponding r_i being valid (>=1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: request one test run.
REQ-008 The block SHALL have port r_i, input, 1 bit: compare result from the SRAM comparator (1 = match).
REQ-009 The block SHALL have port d_o, output, DW bits: write data to the SRAM comparator.
REQ-010 The block SHALL have port we_o, output, 1 bit: write strobe.
REQ-011 The block SHALL have port rd_o, output, 1 bit: read/compare strobe.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a run ends.
REQ-014 The block SHALL have port pass, output, 1 bit: result of the last completed run.
REQ-015 The block SHALL have port err_cnt, output, 16 bits: mismatch count of the current or last run.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, GAP, READ, DRAIN and DONE, and SHALL be registered with registered outputs.
REQ-017 In IDLE, start=1 SHALL move the FSM to WRITE on that edge, clear err_cnt, clear pass and reset the word counter to 0.
REQ-018 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-019 WRITE SHALL last exactly DEPTH cycles with we_o=1, rd_o=0 and d_o = word counter zero-extended to DW, giving 0..DEPTH-1.
REQ-020 GAP SHALL last exactly GAP cycles with we_o=0, rd_o=0 and d_o=0; when GAP=0 the FSM SHALL go straight from WRITE to READ.
REQ-021 READ SHALL last exactly DEPTH cycles with rd_o=1, we_o=0 and d_o=0.
REQ-022 DRAIN SHALL last exactly RD_LAT cycles with all strobes at 0.
REQ-023 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-024 busy SHALL be 1 in WRITE, GAP, READ, DRAIN and DONE, and 0 in IDLE.
REQ-025 A valid-sample shift register of depth RD_LAT SHALL track rd_o; r_i SHALL be sampled only in cycles exactly RD_LAT after an rd_o=1 cycle.
REQ-026 r_i SHALL be ignored in all other cycles.
REQ-027 Each sampled r_i=0 SHALL increment err_cnt by 1, saturating at 16'hFFFF.
REQ-028 pass SHALL be set in DONE to (err_cnt==0, including a mismatch sampled in the final DRAIN cycle) and held until the next accepted start or reset.
REQ-029 Run length from the start-accept edge to the done cycle SHALL be 2*DEPTH+GAP+RD_LAT+1 cycles; with defaults this is 524.

Reset
REQ-030 rst=0 at a rising edge SHALL force state IDLE and set d_o=0, we_o=0, rd_o=0, busy=0, done=0, pass=0, err_cnt=0, word counter 0 and the valid shift register to 0.
REQ-031 Reset SHALL take effect from any state, including mid-WRITE and mid-READ, with no done pulse and no partial result.
REQ-032 start SHALL be ignored while rst=0.

Verification
REQ-033 The bench SHALL apply defaults with r_i=1 constant and a 1-cycle start, and check: we_o high for 256 cycles with d_o 0..255, 10 idle cycles, rd_o high for 256 cycles, done at cycle 524, pass=1, err_cnt=0.
REQ-034 The bench SHALL drive r_i=0 in the sample slots for read words 0, 100 and 255, and check err_cnt=3 and pass=0 after done.
REQ-035 The bench SHALL drive r_i=0 during WRITE, GAP and IDLE only, and check err_cnt=0 and pass=1.
REQ-036 The bench SHALL assert rst=0 at read word 50, and check all outputs 0 on the next cycle; a fresh start SHALL then give a full 524-cycle run.
REQ-037 The bench SHALL hold start=1 continuously, and check the runs are back-to-back with exactly one IDLE cycle between the done pulse and the next WRITE.
REQ-038 The bench SHALL set DEPTH=4, GAP=0, RD_LAT=2, and check 4 write cycles, then 4 read cycles, 2 drain cycles, and done at cycle 11.
